// File: rtl/serial_ripple_borrow_subtractor_8b.sv
// serial_ripple_borrow_subtractor_8b: bit-serial LSB-first a - b - bin with start/busy/done handshake.
// Optional macro SUB_OVERFLOW_EN adds the o_ovf signed-overflow output.
module serial_ripple_borrow_subtractor_8b #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
`ifdef SUB_OVERFLOW_EN
    output logic             o_ovf,
`endif
    output logic             o_bout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_work, w_shift;
    logic             r_br;
    logic             w_ai, w_bi, w_d, w_br_next, w_last, w_accept;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == S_IDLE) ? (i_start ? S_RUN : S_IDLE) : (w_last ? S_IDLE : S_RUN);
    end
    always_comb begin
        o_busy   = (r_state == S_RUN);
        w_accept = (r_state == S_IDLE) && i_start;
        w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
    end
    // Operands shift right so the current bit is always at index 0.
    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_d       = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    always_comb begin
        w_shift            = r_work >> 1;
        w_shift[WIDTH-1]   = w_d;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_work <= '0;
            o_done <= 1'b0;
            o_diff <= '0;
            o_bout <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            o_ovf  <= 1'b0;
`endif
        end else begin
            o_done <= w_last;
            if (w_accept) begin
                r_a    <= i_a;
                r_b    <= i_b;
                r_br   <= i_bin;
                r_cnt  <= '0;
                r_work <= '0;
            end else if (o_busy) begin
                r_a    <= r_a >> 1;
                r_b    <= r_b >> 1;
                r_br   <= w_br_next;
                r_cnt  <= r_cnt + 1'b1;
                r_work <= w_shift;
                // On the final bit r_a[0]/r_b[0] are the operand MSBs.
                if (w_last) begin
                    o_diff <= w_shift;
                    o_bout <= w_br_next;
`ifdef SUB_OVERFLOW_EN
                    o_ovf  <= (w_ai ^ w_bi) & (w_d ^ w_ai);
`endif
                end
            end
        end
    end
endmodule
